// File: rtl/ex_mc.sv
// ex_mc: parametrised execute stage placed between the ID/EX and EX/MEM registers.
// Logic, shift and add/sub results are combinational. Unsigned division uses an
// iterative restoring divider and holds the pipeline through stallreq_o.
// Optional build macro: EX_SIGNED_DIV_EN adds signed DIV (8'h1A) on the same core.
module ex_mc #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W-1:0]     rem_o,
    output logic                  stallreq_o
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_DIVU = 8'h1B;
`ifdef EX_SIGNED_DIV_EN
    localparam logic [7:0] OP_DIV  = 8'h1A;
`endif

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [SHAMT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0]   quo_reg;   // dividend shifts out MSB-first, quotient shifts in
    logic [DATA_W-1:0]   rem_reg;   // partial remainder
    logic [DATA_W-1:0]   dvs_reg;   // divisor magnitude
    logic                neg_q_reg; // negate quotient on output (signed, signs differ)
    logic                neg_r_reg; // negate remainder on output (signed, dividend negative)

    // ---------------------------------------------------------------
    // Divide decode and operand magnitudes
    // ---------------------------------------------------------------
    logic is_divu;
    logic is_sdiv;
    logic is_div;

    assign is_divu = (aluop_i == OP_DIVU);
`ifdef EX_SIGNED_DIV_EN
    assign is_sdiv = (aluop_i == OP_DIV);
`else
    assign is_sdiv = 1'b0;
`endif
    assign is_div = is_divu | is_sdiv;

    logic              dvd_neg;
    logic              dvs_neg;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;

    // Signed operands enter the unsigned core as magnitudes; the most-negative
    // value maps onto itself, which is its correct unsigned magnitude.
    assign dvd_neg = is_sdiv & reg1_i[DATA_W-1];
    assign dvs_neg = is_sdiv & reg2_i[DATA_W-1];
    assign dvd_mag = dvd_neg ? -reg1_i : reg1_i;
    assign dvs_mag = dvs_neg ? -reg2_i : reg2_i;

    // One restoring step: shift in the next dividend bit, try to subtract.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    assign shifted = {rem_reg, quo_reg[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_reg};

    // ---------------------------------------------------------------
    // Divider FSM: IDLE -> BUSY (DATA_W steps) -> DONE -> IDLE
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_div) begin
                        if (reg2_i == '0) begin
                            // Divide by zero: fixed result, no iteration, no sign fix-up.
                            quo_reg   <= '1;
                            rem_reg   <= reg1_i;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            quo_reg   <= dvd_mag;
                            rem_reg   <= '0;
                            dvs_reg   <= dvs_mag;
                            neg_q_reg <= dvd_neg ^ dvs_neg;
                            neg_r_reg <= dvd_neg;
                            cnt_reg   <= '0;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                    end else begin
                        quo_reg <= {quo_reg[DATA_W-2:0], ~trial[DATA_W]};
                        rem_reg <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                        cnt_reg <= cnt_reg + SHAMT_W'(1);
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Combinational result paths
    // ---------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  quo_out;
    logic [DATA_W-1:0]  rem_out;
    logic               div_done;
    logic [DATA_W-1:0]  logic_res;
    logic [DATA_W-1:0]  shift_res;
    logic [DATA_W-1:0]  arith_res;
    logic [DATA_W-1:0]  sel_res;
    logic               stall;

    assign shamt    = reg1_i[SHAMT_W-1:0];
    assign quo_out  = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_out  = neg_r_reg ? -rem_reg : rem_reg;
    assign div_done = (state_reg == DONE) & is_div;

    // Bitwise logic unit.
    always_comb begin
        logic_res = '0;
        case (aluop_i)
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    // Barrel shifter: reg2 is the value, reg1 low bits the amount.
    always_comb begin
        shift_res = '0;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << shamt;
            OP_SRL:  shift_res = reg2_i >> shamt;
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> shamt);
            default: shift_res = '0;
        endcase
    end

    // Add/sub plus the committed divide quotient.
    always_comb begin
        arith_res = '0;
        case (aluop_i)
            OP_ADDU: arith_res = reg1_i + reg2_i;
            OP_SUBU: arith_res = reg1_i - reg2_i;
            default: arith_res = div_done ? quo_out : '0;
        endcase
    end

    // Result select.
    always_comb begin
        sel_res = '0;
        case (alusel_i)
            SEL_LOGIC: sel_res = logic_res;
            SEL_SHIFT: sel_res = shift_res;
            SEL_ARITH: sel_res = arith_res;
            default:   sel_res = '0;
        endcase
    end

    // Stall while a divide is being accepted or iterating.
    assign stall = ((state_reg == IDLE) & is_div) | (state_reg == BUSY);

    // Reset forces every output low regardless of the inputs.
    assign stallreq_o = rst & stall;
    assign wd_o       = rst ? wd_i : '0;
    assign wdata_o    = rst ? sel_res : '0;
    assign rem_o      = (rst & div_done) ? rem_out : '0;
    assign wreg_o     = rst & wreg_i & ~stall & ~(flush_i & (state_reg == DONE));

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc: randomized self-checking bench for ex_mc against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_mc;
    localparam int W  = 32;
    localparam int AW = 5;

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_DIV  = 8'h1A;

    localparam logic [2:0] S_LOG = 3'b001;
    localparam logic [2:0] S_SHF = 3'b010;
    localparam logic [2:0] S_ART = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    aluop_i = '0;
    logic [2:0]    alusel_i = '0;
    logic [W-1:0]  reg1_i = '0;
    logic [W-1:0]  reg2_i = '0;
    logic [AW-1:0] wd_i = '0;
    logic          wreg_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW-1:0] wd_o;
    logic          wreg_o;
    logic [W-1:0]  wdata_o;
    logic [W-1:0]  rem_o;
    logic          stallreq_o;

    int checks = 0;
    int errors = 0;

    ex_mc #(.DATA_W(W), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .rem_o(rem_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    // Reference model for single-cycle ops, straight from the op table.
    function automatic logic [W-1:0] model_single(input logic [7:0] op, input logic [2:0] sel,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned sh = a[4:0];
        logic [W-1:0] ones = '1;
        logic [W-1:0] r = '0;
        if (sel == S_LOG) begin
            if (op == OP_OR) r = a | b;
            else if (op == OP_AND) r = a & b;
            else if (op == OP_XOR) r = a ^ b;
            else if (op == OP_NOR) r = ~(a | b);
        end else if (sel == S_SHF) begin
            if (op == OP_SLL) r = b << sh;
            else if (op == OP_SRL) r = b >> sh;
            else if (op == OP_SRA) r = (b >> sh) | (b[W-1] ? ~(ones >> sh) : '0);
        end else if (sel == S_ART) begin
            if (op == OP_ADDU) r = a + b;
            else if (op == OP_SUBU) r = a - b;
        end
        return r;
    endfunction

    function automatic bit is_div_op(input logic [7:0] op);
`ifdef EX_SIGNED_DIV_EN
        return (op == OP_DIVU) || (op == OP_DIV);
`else
        return (op == OP_DIVU);
`endif
    endfunction

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [AW-1:0] wd, input logic wr);
        @(posedge clk);
        #1;
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    endtask

    // Applies one single-cycle op and checks every output in that same cycle.
    task automatic single_op(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp, input string name);
        logic [AW-1:0] wd = AW'($urandom);
        logic wr = 1'(($urandom & 3) != 0);
        drive(op, sel, a, b, wd, wr);
        @(negedge clk);
        $display("txn %s op=%h sel=%b a=%h b=%h wdata=%h stall=%b", name, op, sel, a, b, wdata_o, stallreq_o);
        checks++; if (wdata_o !== exp) begin errors++; $display("FAIL %s wdata got %h exp %h", name, wdata_o, exp); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL %s stall got %b exp 0", name, stallreq_o); end
        checks++; if (wreg_o !== wr) begin errors++; $display("FAIL %s wreg got %b exp %b", name, wreg_o, wr); end
        checks++; if (wd_o !== wd) begin errors++; $display("FAIL %s wd got %h exp %h", name, wd_o, wd); end
        checks++; if (rem_o !== '0) begin errors++; $display("FAIL %s rem got %h exp 0", name, rem_o); end
    endtask

    // Runs one divide to completion, checking stall length and the committed result.
    task automatic do_div(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] wd, input logic wr, input logic [W-1:0] exp_q,
                          input logic [W-1:0] exp_r, input string name);
        int stalls = 0;
        int exp_stalls = (b == '0) ? 1 : W + 1;
        drive(op, S_ART, a, b, wd, wr);
        @(negedge clk);
        while (stallreq_o === 1'b1 && stalls < 100) begin
            checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL %s wreg during stall got %b exp 0", name, wreg_o); end
            stalls++;
            @(negedge clk);
        end
        $display("txn %s op=%h a=%h b=%h q=%h r=%h stalls=%0d", name, op, a, b, wdata_o, rem_o, stalls);
        checks++; if (stalls != exp_stalls) begin errors++; $display("FAIL %s stall cycles got %0d exp %0d", name, stalls, exp_stalls); end
        checks++; if (wdata_o !== exp_q) begin errors++; $display("FAIL %s quotient got %h exp %h", name, wdata_o, exp_q); end
        checks++; if (rem_o !== exp_r) begin errors++; $display("FAIL %s remainder got %h exp %h", name, rem_o, exp_r); end
        checks++; if (wreg_o !== wr) begin errors++; $display("FAIL %s wreg got %b exp %b", name, wreg_o, wr); end
        checks++; if (wd_o !== wd) begin errors++; $display("FAIL %s wd got %h exp %h", name, wd_o, wd); end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++; if (wdata_o !== '0) begin errors++; $display("FAIL %s wdata got %h exp 0", name, wdata_o); end
        checks++; if (rem_o !== '0) begin errors++; $display("FAIL %s rem got %h exp 0", name, rem_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL %s wreg got %b exp 0", name, wreg_o); end
        checks++; if (wd_o !== '0) begin errors++; $display("FAIL %s wd got %h exp 0", name, wd_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL %s stall got %b exp 0", name, stallreq_o); end
    endtask

    task automatic test_reset();
        logic [7:0] ops [4] = '{OP_DIVU, OP_OR, OP_ADDU, OP_SRA};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], S_ART | S_LOG, $urandom, $urandom | 1, AW'($urandom | 1), 1'b1);
            @(negedge clk);
            $display("txn reset op=%h", ops[i]);
            check_zero_outputs("reset");
        end
        @(posedge clk); #1;
        aluop_i = OP_OR; alusel_i = S_LOG; rst = 1'b1;
    endtask

    task automatic test_vectors();
        single_op(OP_OR,  S_LOG, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFFF0_FFFF, "vec_or");
        single_op(OP_AND, S_LOG, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h00F0_0000, "vec_and");
        single_op(OP_XOR, S_LOG, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFF00_FFFF, "vec_xor");
        single_op(OP_NOR, S_LOG, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h000F_0000, "vec_nor");
        single_op(OP_SRA, S_SHF, 32'd4, 32'h8000_0010, 32'hF800_0001, "vec_sra");
        single_op(OP_SLL, S_SHF, 32'd33, 32'd1, 32'd2, "vec_sll");
        single_op(OP_SUBU, S_ART, 32'd0, 32'd1, 32'hFFFF_FFFF, "vec_subu");
        single_op(OP_ADDU, S_LOG, 32'd5, 32'd6, 32'd0, "vec_wrong_sel");
        single_op(OP_OR, 3'b011, 32'd5, 32'd6, 32'd0, "vec_bad_sel");
    endtask

    task automatic test_random_single();
        logic [7:0] pool [10] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ADDU, OP_SUBU, 8'h00};
        logic [2:0] sels [3] = '{S_LOG, S_SHF, S_ART};
        for (int i = 0; i < 80; i++) begin
            logic [7:0] op = pool[$urandom_range(0, 9)];
            logic [2:0] sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : sels[$urandom_range(0, 2)];
            logic [W-1:0] a = $urandom;
            logic [W-1:0] b = $urandom;
            if (op == 8'h00) begin
                do op = 8'($urandom); while (is_div_op(op));
            end
            single_op(op, sel, a, b, model_single(op, sel, a, b), "rand_single");
        end
    endtask

    task automatic test_divu();
        logic [W-1:0] a2 = $urandom;
        logic [W-1:0] b2 = $urandom;
        do_div(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, 32'd2, "divu_100_7");
        single_op(OP_ADDU, S_ART, a2, b2, a2 + b2, "after_divu_idle");
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a = $urandom;
            logic [W-1:0] b = $urandom >> $urandom_range(0, 31);
            if (i == 5) b = a + 1;
            do_div(OP_DIVU, a, b, AW'($urandom), 1'($urandom), (b == 0) ? '1 : a / b, (b == 0) ? a : a % b, "divu_rand");
        end
    endtask

    task automatic test_div_zero();
        do_div(OP_DIVU, 32'd9, 32'd0, 5'd3, 1'b1, 32'hFFFF_FFFF, 32'd9, "divu_9_0");
        // Divide by zero again, flushed in its DONE cycle: result not written back.
        drive(OP_DIVU, S_ART, 32'd9, 32'd0, 5'd3, 1'b1);
        @(negedge clk);
        @(posedge clk); #1; flush_i = 1'b1;
        @(negedge clk);
        $display("txn flush_done wreg=%b stall=%b", wreg_o, stallreq_o);
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL flush_done wreg got %b exp 0", wreg_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_done stall got %b exp 0", stallreq_o); end
        @(posedge clk); #1; flush_i = 1'b0;
        aluop_i = OP_OR; alusel_i = S_LOG;
    endtask

    task automatic test_flush();
        drive(OP_DIVU, S_ART, $urandom, 32'd3, 5'd7, 1'b1);
        for (int i = 1; i <= 10; i++) @(posedge clk);
        #1; flush_i = 1'b1;
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_busy stall got %b exp 1", stallreq_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL flush_busy wreg got %b exp 0", wreg_o); end
        @(posedge clk); #1; flush_i = 1'b0;
        aluop_i = OP_ADDU; alusel_i = S_ART; reg1_i = 32'd2; reg2_i = 32'd3; wd_i = 5'd9; wreg_i = 1'b1;
        @(negedge clk);
        $display("txn flush then addu wdata=%h stall=%b", wdata_o, stallreq_o);
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_after stall got %b exp 0", stallreq_o); end
        checks++; if (wdata_o !== 32'd5) begin errors++; $display("FAIL flush_after wdata got %h exp 5", wdata_o); end
        checks++; if (wreg_o !== 1'b1) begin errors++; $display("FAIL flush_after wreg got %b exp 1", wreg_o); end
    endtask

    task automatic test_reset_mid();
        drive(OP_DIVU, S_ART, 32'd1000, 32'd7, 5'd11, 1'b1);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1; rst = 1'b0;
        #1;
        $display("txn reset_mid stall=%b wdata=%h", stallreq_o, wdata_o);
        check_zero_outputs("reset_mid");
        @(negedge clk);
        aluop_i = OP_OR; alusel_i = S_LOG;
        @(posedge clk); #1; rst = 1'b1;
        do_div(OP_DIVU, 32'd8, 32'd2, 5'd4, 1'b1, 32'd4, 32'd0, "divu_8_2");
    endtask

`ifdef EX_SIGNED_DIV_EN
    task automatic test_signed();
        logic [W-1:0] mn = 32'h8000_0000;
        do_div(OP_DIV, -32'sd7, 32'd2, 5'd2, 1'b1, -32'sd3, -32'sd1, "div_m7_2");
        do_div(OP_DIV, mn, '1, 5'd2, 1'b1, mn, 32'd0, "div_min_m1");
        do_div(OP_DIV, -32'sd9, 32'd0, 5'd2, 1'b1, '1, -32'sd9, "div_by_zero");
        for (int i = 0; i < 4; i++) begin
            int sa = $urandom;
            int sb = int'($urandom >> $urandom_range(1, 31)) + 1;
            if (i[0]) sb = -sb;
            do_div(OP_DIV, sa, sb, AW'($urandom), 1'b1, sa / sb, sa % sb, "div_rand");
        end
    endtask
`else
    task automatic test_signed();
        single_op(OP_DIV, S_ART, -32'sd7, 32'd2, 32'd0, "div_disabled");
        single_op(OP_DIV, S_ART, $urandom, 32'd0, 32'd0, "div_disabled_zero");
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_random_single();
        test_divu();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_signed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck divider cannot hang the run.
    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
